// File: rtl/funct_issue_ctrl_pkg.sv
// Shared opcode/funct constants and FSM state encoding for the ALU funct issue controller.
package funct_issue_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FUNCT_NOP   = 6'h00;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/funct_decode.sv
// Combinational decode of (op, funct_in) into ALU funct, multi-cycle flag and mul/div select.
module funct_decode
    import funct_issue_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int FUNCT_W       = 6,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    output logic [FUNCT_W-1:0] funct,
    output logic               is_multi,
    output logic               div_sel
);

    always_comb begin
        funct = FUNCT_NOP;
        case (op)
            OP_SPECIAL:                                   funct = funct_in;
            OP_LUI, OP_JAL, OP_ORI:                       funct = FUNCT_OR;
            OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW, OP_ADDIU: funct = FUNCT_ADDU;
            OP_ANDI:                                      funct = FUNCT_AND;
            OP_XORI:                                      funct = FUNCT_XOR;
            OP_SLTI:                                      funct = FUNCT_SLT;
            OP_SLTIU:                                     funct = FUNCT_SLTU;
            default:                                      funct = FUNCT_NOP;
        endcase
    end

    assign is_multi = ENABLE_MULDIV && (op == OP_SPECIAL) && is_muldiv_funct(funct_in);
    // DIV/DIVU (1A/1B) differ from MULT/MULTU (18/19) only in bit 1.
    assign div_sel  = funct_in[1];

endmodule

// File: rtl/funct_issue_ctrl.sv
// Registered, handshaked ALU funct issue stage with multi-cycle mul/div sequencing.
module funct_issue_ctrl
    import funct_issue_ctrl_pkg::*;
#(
    parameter int OP_W          = 6,
    parameter int FUNCT_W       = 6,
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 33,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FUNCT_W-1:0] funct_out,
    output logic               is_multi,
    output logic               md_start,
    output logic               md_abort,
    output logic               stall_req
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [FUNCT_W-1:0] dec_funct;
    logic               dec_multi;
    logic               dec_div;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FUNCT_W-1:0] funct_q;
    logic               out_valid_q;
    logic               is_multi_q;
    logic               md_start_q;
    logic               md_abort_q;
    logic               stall_q;
    logic               accept;

    funct_decode #(
        .OP_W          (OP_W),
        .FUNCT_W       (FUNCT_W),
        .ENABLE_MULDIV (ENABLE_MULDIV)
    ) u_decode (
        .op       (op),
        .funct_in (funct_in),
        .funct    (dec_funct),
        .is_multi (dec_multi),
        .div_sel  (dec_div)
    );

    assign in_ready = !flush && (state_q != ST_BUSY) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            funct_q     <= FUNCT_NOP;
            out_valid_q <= 1'b0;
            is_multi_q  <= 1'b0;
            md_start_q  <= 1'b0;
            md_abort_q  <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            md_start_q <= 1'b0;
            md_abort_q <= 1'b0;
            if (flush) begin
                md_abort_q  <= (state_q == ST_BUSY);
                state_q     <= ST_IDLE;
                cnt_q       <= '0;
                out_valid_q <= 1'b0;
                is_multi_q  <= 1'b0;
                stall_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_BUSY: begin
                        if (cnt_q == '0) begin
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                            is_multi_q  <= 1'b1;
                            stall_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        if (accept) begin
                            // Multi-cycle funct is latched here; invisible until out_valid rises.
                            funct_q <= dec_funct;
                            if (dec_multi) begin
                                state_q     <= ST_BUSY;
                                md_start_q  <= 1'b1;
                                stall_q     <= 1'b1;
                                out_valid_q <= 1'b0;
                                is_multi_q  <= 1'b0;
                                cnt_q       <= dec_div ? DIV_LOAD : MUL_LOAD;
                            end else begin
                                state_q     <= ST_HOLD;
                                out_valid_q <= 1'b1;
                                is_multi_q  <= 1'b0;
                            end
                        end else if (out_ready) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            is_multi_q  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_q;
    assign funct_out = funct_q;
    assign is_multi  = is_multi_q;
    assign md_start  = md_start_q;
    assign md_abort  = md_abort_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_funct_issue_ctrl.sv
// Directed bench for funct_issue_ctrl: decode table plus hand-written multi-cycle sequences.
module tb_funct_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] op;
    logic [5:0] funct_in;
    logic       flush;
    logic       out_ready;

    logic       in_ready, out_valid, is_multi, md_start, md_abort, stall_req;
    logic [5:0] funct_out;
    logic       n_in_ready, n_out_valid, n_is_multi, n_md_start, n_md_abort, n_stall_req;
    logic [5:0] n_funct_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    funct_issue_ctrl #(
        .OP_W(6), .FUNCT_W(6), .MUL_CYCLES(4), .DIV_CYCLES(33), .ENABLE_MULDIV(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct_in(funct_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .funct_out(funct_out),
        .is_multi(is_multi), .md_start(md_start), .md_abort(md_abort),
        .stall_req(stall_req)
    );

    funct_issue_ctrl #(
        .OP_W(6), .FUNCT_W(6), .MUL_CYCLES(4), .DIV_CYCLES(33), .ENABLE_MULDIV(1'b0)
    ) dut_nomd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .op(op), .funct_in(funct_in), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready), .funct_out(n_funct_out),
        .is_multi(n_is_multi), .md_start(n_md_start), .md_abort(n_md_abort),
        .stall_req(n_stall_req)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f);
        in_valid = v;
        op       = o;
        funct_in = f;
    endtask

    initial begin
        vecs[0]  = '{6'h09, 6'h00, 6'h21};
        vecs[1]  = '{6'h23, 6'h00, 6'h21};
        vecs[2]  = '{6'h0F, 6'h00, 6'h25};
        vecs[3]  = '{6'h0C, 6'h00, 6'h24};
        vecs[4]  = '{6'h0B, 6'h00, 6'h2B};
        vecs[5]  = '{6'h3F, 6'h21, 6'h00};
        vecs[6]  = '{6'h0E, 6'h00, 6'h26};
        vecs[7]  = '{6'h0A, 6'h00, 6'h2A};
        vecs[8]  = '{6'h0D, 6'h00, 6'h25};
        vecs[9]  = '{6'h03, 6'h00, 6'h25};
        vecs[10] = '{6'h28, 6'h00, 6'h21};
        vecs[11] = '{6'h00, 6'h26, 6'h26};
        vecs[12] = '{6'h24, 6'h00, 6'h21};

        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 6'h00, 6'h00);

        // Reset
        #12;
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_funct_out", {2'b0, funct_out}, 8'h00);
        chk("rst_is_multi",  {7'b0, is_multi},  8'h00);
        chk("rst_md_start",  {7'b0, md_start},  8'h00);
        chk("rst_md_abort",  {7'b0, md_abort},  8'h00);
        chk("rst_stall",     {7'b0, stall_req}, 8'h00);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rel_in_ready", {7'b0, in_ready}, 8'h01);

        // Decode sweep, one accept per cycle
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].fn);
            #1;
            chk($sformatf("sweep%0d_in_ready", i), {7'b0, in_ready}, 8'h01);
            tick();
            chk($sformatf("sweep%0d_out_valid", i), {7'b0, out_valid}, 8'h01);
            chk($sformatf("sweep%0d_funct", i), {2'b0, funct_out}, {2'b0, vecs[i].exp});
            chk($sformatf("sweep%0d_is_multi", i), {7'b0, is_multi}, 8'h00);
        end
        drive(1'b0, 6'h00, 6'h00);
        tick();
        chk("drain_out_valid", {7'b0, out_valid}, 8'h00);

        // MULT: 4 BUSY cycles, result in cycle 5
        drive(1'b1, 6'h00, 6'h18);
        tick();
        drive(1'b0, 6'h00, 6'h00);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("mult_c%0d_md_start", c), {7'b0, md_start}, (c == 1) ? 8'h01 : 8'h00);
            chk($sformatf("mult_c%0d_stall", c), {7'b0, stall_req}, 8'h01);
            chk($sformatf("mult_c%0d_in_ready", c), {7'b0, in_ready}, 8'h00);
            chk($sformatf("mult_c%0d_out_valid", c), {7'b0, out_valid}, 8'h00);
            tick();
        end
        chk("mult_out_valid", {7'b0, out_valid}, 8'h01);
        chk("mult_funct",     {2'b0, funct_out}, 8'h18);
        chk("mult_is_multi",  {7'b0, is_multi},  8'h01);
        chk("mult_stall_end", {7'b0, stall_req}, 8'h00);
        tick();
        chk("mult_drain", {7'b0, out_valid}, 8'h00);

        // DIV flushed on 10th BUSY cycle
        drive(1'b1, 6'h00, 6'h1A);
        tick();
        drive(1'b0, 6'h00, 6'h00);
        for (int c = 2; c <= 10; c++) tick();
        chk("div_c10_stall", {7'b0, stall_req}, 8'h01);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("div_md_abort",  {7'b0, md_abort},  8'h01);
        chk("div_out_valid", {7'b0, out_valid}, 8'h00);
        chk("div_stall",     {7'b0, stall_req}, 8'h00);
        chk("div_in_ready",  {7'b0, in_ready},  8'h01);
        tick();
        chk("div_abort_once", {7'b0, md_abort}, 8'h00);
        for (int c = 0; c < 30; c++) tick();
        chk("div_no_late_valid", {7'b0, out_valid}, 8'h00);

        // Flush beats completion on the cnt==0 cycle
        drive(1'b1, 6'h00, 6'h19);
        tick();
        drive(1'b0, 6'h00, 6'h00);
        for (int c = 2; c <= 4; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fc_out_valid", {7'b0, out_valid}, 8'h00);
        chk("fc_is_multi",  {7'b0, is_multi},  8'h00);
        chk("fc_md_abort",  {7'b0, md_abort},  8'h01);
        tick();
        chk("fc_still_idle", {7'b0, out_valid}, 8'h00);

        // Flush beats same-cycle in_valid
        drive(1'b1, 6'h0E, 6'h00);
        flush = 1'b1;
        #1;
        chk("fi_in_ready", {7'b0, in_ready}, 8'h00);
        tick();
        flush = 1'b0;
        drive(1'b0, 6'h00, 6'h00);
        chk("fi_out_valid", {7'b0, out_valid}, 8'h00);
        chk("fi_md_abort",  {7'b0, md_abort},  8'h00);

        // Backpressure
        drive(1'b1, 6'h00, 6'h21);
        tick();
        chk("bp_first", {2'b0, funct_out}, 8'h21);
        out_ready = 1'b0;
        drive(1'b1, 6'h0E, 6'h00);
        #1;
        chk("bp_in_ready_lo", {7'b0, in_ready}, 8'h00);
        tick();
        tick();
        chk("bp_hold_funct", {2'b0, funct_out}, 8'h21);
        chk("bp_hold_valid", {7'b0, out_valid}, 8'h01);
        drive(1'b1, 6'h09, 6'h00);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_hi", {7'b0, in_ready}, 8'h01);
        tick();
        drive(1'b0, 6'h00, 6'h00);
        chk("bp_addiu_valid", {7'b0, out_valid}, 8'h01);
        chk("bp_addiu_funct", {2'b0, funct_out}, 8'h21);
        tick();
        chk("bp_drain", {7'b0, out_valid}, 8'h00);

        // MULTU: single-cycle without mul/div; async reset mid-BUSY with it
        drive(1'b1, 6'h00, 6'h19);
        tick();
        drive(1'b0, 6'h00, 6'h00);
        chk("nomd_out_valid", {7'b0, n_out_valid}, 8'h01);
        chk("nomd_funct",     {2'b0, n_funct_out}, 8'h19);
        chk("nomd_is_multi",  {7'b0, n_is_multi},  8'h00);
        chk("nomd_md_start",  {7'b0, n_md_start},  8'h00);
        chk("md_busy_start",  {7'b0, md_start},    8'h01);
        tick();
        chk("md_busy_stall", {7'b0, stall_req}, 8'h01);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_stall",     {7'b0, stall_req}, 8'h00);
        chk("arst_funct",     {2'b0, funct_out}, 8'h00);
        chk("arst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("arst_md_start",  {7'b0, md_start},  8'h00);
        tick();
        chk("arst_md_abort", {7'b0, md_abort}, 8'h00);
        rst = 1'b1;
        tick();
        chk("arst_in_ready", {7'b0, in_ready}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
